// File: rtl/xbus_arbiter.sv
// xbus_arbiter: shares the single xbus slave port between two masters
// (m0 = CPU core, m1 = DMA / loader). Zero-latency grant, round-robin on
// ties, bounded tenure of MAX_HOLD cycles under contention, and a per-master
// lock that stretches an existing tenure for atomic sequences.
module xbus_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        xbus_as,
  output logic        xbus_we,
  output logic [3:0]  xbus_be,
  output logic [31:0] xbus_addr,
  output logic [31:0] xbus_wdata,
  input  logic [31:0] xbus_rdata
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last;
  logic [HW-1:0] hold_cnt;
  logic          gnt0;
  logic          gnt1;
  logic          tenure_open;

  // The current owner may keep the bus while it is locked, while nobody else
  // is asking, or while its tenure has not yet reached MAX_HOLD.
  assign tenure_open = (hold_cnt < HOLD_MAX);

  // Grant decision and next owner; reset suppresses any grant in its cycle.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = IDLE;
    if (!rst) begin
      unique case (state)
        OWN0: begin
          if (m0_req) begin
            if (m0_lock || !m1_req || tenure_open) gnt0 = 1'b1;
            else                                   gnt1 = 1'b1;
          end else if (m1_req) begin
            gnt1 = 1'b1;
          end
        end
        OWN1: begin
          if (m1_req) begin
            if (m1_lock || !m0_req || tenure_open) gnt1 = 1'b1;
            else                                   gnt0 = 1'b1;
          end else if (m0_req) begin
            gnt0 = 1'b1;
          end
        end
        default: begin
          if (m0_req && m1_req) begin
            if (last) gnt0 = 1'b1;
            else      gnt1 = 1'b1;
          end else if (m0_req) begin
            gnt0 = 1'b1;
          end else if (m1_req) begin
            gnt1 = 1'b1;
          end
        end
      endcase
      if (gnt0)      state_nxt = OWN0;
      else if (gnt1) state_nxt = OWN1;
    end
  end

  // Owner, last-served pointer and saturating tenure counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (gnt0 || gnt1) begin
        last <= gnt1;
        if ((gnt0 && state == OWN0) || (gnt1 && state == OWN1)) begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HOLD_ONE;
        end else begin
          hold_cnt <= HOLD_ONE;
        end
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  // Steer the granted master onto the slave port; everything is 0 when idle.
  always_comb begin
    m0_gnt     = gnt0;
    m1_gnt     = gnt1;
    xbus_as    = gnt0 | gnt1;
    xbus_we    = 1'b0;
    xbus_be    = 4'h0;
    xbus_addr  = 32'h0;
    xbus_wdata = 32'h0;
    m0_rdata   = 32'h0;
    m1_rdata   = 32'h0;
    if (gnt0) begin
      xbus_we    = m0_we;
      xbus_be    = m0_be;
      xbus_addr  = m0_addr;
      xbus_wdata = m0_wdata;
      m0_rdata   = xbus_rdata;
    end else if (gnt1) begin
      xbus_we    = m1_we;
      xbus_be    = m1_be;
      xbus_addr  = m1_addr;
      xbus_wdata = m1_wdata;
      m1_rdata   = xbus_rdata;
    end
  end

endmodule
